// File: rtl/rnn_pkg.sv
// Shared types, constants and helpers for the RNN matrix-vector sequencer.
//   fixed_t : signed DATA_W fixed-point element
//   idx_t   : row/column index
//   acc_t   : signed MAC accumulator (wide enough that no overflow occurs before saturation)
//   state_t : sequencer FSM encoding
package rnn_pkg;

   localparam int unsigned DATA_W    = 16;
   localparam int unsigned IDX_W     = 8;
   localparam int unsigned FRAC_BITS = 8;
   localparam int unsigned ACC_W     = 2*DATA_W + IDX_W;

   typedef logic signed [DATA_W-1:0] fixed_t;
   typedef logic        [IDX_W-1:0]  idx_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   typedef logic [2:0] state_t;
   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_ISSUE = 3'd1;
   localparam state_t S_DRAIN = 3'd2;
   localparam state_t S_WRITE = 3'd3;
   localparam state_t S_DONE  = 3'd4;

   localparam acc_t FIX_MAX = acc_t'({1'b0, {(DATA_W-1){1'b1}}});
   localparam acc_t FIX_MIN = -FIX_MAX - acc_t'(1);

   // Arithmetic shift (floor, no rounding), then clamp to the fixed_t range
   function automatic fixed_t sat_shift(input acc_t acc, input int unsigned sh);
      acc_t s;
      s = acc >>> sh;
      if (s > FIX_MAX)      return fixed_t'(FIX_MAX);
      else if (s < FIX_MIN) return fixed_t'(FIX_MIN);
      else                  return fixed_t'(s);
   endfunction

endpackage

// File: rtl/rnn_mv_seq_if.sv
// Control and storage-side bus of the matrix-vector sequencer.
//   slave  : the sequencer (takes start/abort/config and read data, drives addresses, writes, status)
//   master : the register block / storage side
interface rnn_mv_seq_if;
   import rnn_pkg::*;

   logic   start;
   logic   abort;
   idx_t   rows_cfg;
   idx_t   cols_cfg;
   logic   busy;
   logic   done;
   idx_t   w_row;
   idx_t   w_col;
   fixed_t w_data;
   idx_t   x_idx;
   fixed_t x_data;
   logic   h_we;
   idx_t   h_idx;
   fixed_t h_data;

   modport slave (
      input  start, abort, rows_cfg, cols_cfg, w_data, x_data,
      output busy, done, w_row, w_col, x_idx, h_we, h_idx, h_data
   );

   modport master (
      output start, abort, rows_cfg, cols_cfg, w_data, x_data,
      input  busy, done, w_row, w_col, x_idx, h_we, h_idx, h_data
   );

endinterface

// File: rtl/rnn_mac.sv
// Signed multiply-accumulate unit.
//   i_clear : zero the accumulator (wins over i_en)
//   i_en    : add i_a*i_b to the accumulator
//   o_acc   : registered accumulator
module rnn_mac
   import rnn_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_clear,
   input  logic   i_en,
   input  fixed_t i_a,
   input  fixed_t i_b,
   output acc_t   o_acc
);

   localparam int unsigned PROD_W = 2*DATA_W;

   logic signed [PROD_W-1:0] w_a;
   logic signed [PROD_W-1:0] w_b;
   logic signed [PROD_W-1:0] w_prod;
   acc_t                     r_acc;

   // Sign-extend operands so the full-width product is exact
   assign w_a    = PROD_W'(i_a);
   assign w_b    = PROD_W'(i_b);
   assign w_prod = w_a * w_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_acc <= '0;
      else if (i_clear) r_acc <= '0;
      else if (i_en)    r_acc <= r_acc + ACC_W'(w_prod);
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/rnn_mv_seq.sv
// Sequencer for h = sat((W * x) >>> FRAC_BITS).
// Walks rows/columns of W, fetches W[r][c] and x[c] (1-cycle read latency),
// drives the shared MAC and writes one saturated result per row.
//   clk, rst_n : clock, async active-low reset
//   bus        : start/abort/config in, weight/vector read port, hidden write port, busy/done
module rnn_mv_seq #(
   parameter int unsigned FRAC_BITS = rnn_pkg::FRAC_BITS
) (
   input  logic         clk,
   input  logic         rst_n,
   rnn_mv_seq_if.slave  bus
);
   import rnn_pkg::*;

   state_t r_state, w_state_n;
   idx_t   r_row, w_row_n;
   idx_t   r_col, w_col_n;
   idx_t   r_rows, w_rows_n;
   idx_t   r_cols, w_cols_n;
   logic   r_vld, w_vld_n;
   logic   r_busy, w_busy_n;
   logic   r_done, w_done_n;
   logic   r_h_we, w_h_we_n;
   logic   w_mac_clr;
   acc_t   w_acc;

   // Next-state, counter and status decode
   always_comb begin
      w_state_n = r_state;
      w_row_n   = r_row;
      w_col_n   = r_col;
      w_rows_n  = r_rows;
      w_cols_n  = r_cols;
      w_mac_clr = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_rows_n  = bus.rows_cfg;
               w_cols_n  = bus.cols_cfg;
               w_row_n   = '0;
               w_col_n   = '0;
               w_mac_clr = 1'b1;
               w_state_n = (bus.rows_cfg != '0 && bus.cols_cfg != '0) ? S_ISSUE : S_DONE;
            end
         end
         S_ISSUE: begin
            if (r_col == r_cols - idx_t'(1)) begin
               w_col_n   = '0;
               w_state_n = S_DRAIN;
            end else begin
               w_col_n   = r_col + idx_t'(1);
            end
         end
         S_DRAIN: w_state_n = S_WRITE;
         S_WRITE: begin
            w_mac_clr = 1'b1;
            if (r_row == r_rows - idx_t'(1)) begin
               w_row_n   = '0;
               w_state_n = S_DONE;
            end else begin
               w_row_n   = r_row + idx_t'(1);
               w_state_n = S_ISSUE;
            end
         end
         S_DONE:  w_state_n = S_IDLE;
         default: w_state_n = S_IDLE;
      endcase

      // Abort overrides everything except the write already on the bus this cycle
      if (bus.abort && r_state != S_IDLE) begin
         w_state_n = S_IDLE;
         w_row_n   = '0;
         w_col_n   = '0;
         w_mac_clr = 1'b1;
      end

      // Read data returns one cycle after an ISSUE address
      w_vld_n  = (r_state == S_ISSUE) && (w_state_n != S_IDLE);
      w_busy_n = (w_state_n == S_ISSUE) || (w_state_n == S_DRAIN) || (w_state_n == S_WRITE);
      w_done_n = (w_state_n == S_DONE);
      w_h_we_n = (w_state_n == S_WRITE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_col   <= '0;
         r_rows  <= '0;
         r_cols  <= '0;
         r_vld   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_h_we  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_row   <= w_row_n;
         r_col   <= w_col_n;
         r_rows  <= w_rows_n;
         r_cols  <= w_cols_n;
         r_vld   <= w_vld_n;
         r_busy  <= w_busy_n;
         r_done  <= w_done_n;
         r_h_we  <= w_h_we_n;
      end
   end

   rnn_mac u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_mac_clr),
      .i_en    (r_vld),
      .i_a     (bus.w_data),
      .i_b     (bus.x_data),
      .o_acc   (w_acc)
   );

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.w_row  = r_row;
   assign bus.w_col  = r_col;
   assign bus.x_idx  = r_col;
   assign bus.h_we   = r_h_we;
   assign bus.h_idx  = r_row;
   // Accumulator holds the complete row sum during WRITE; result is zero otherwise
   assign bus.h_data = r_h_we ? sat_shift(w_acc, FRAC_BITS) : '0;

endmodule
